// File: rtl/sprite_pkg.sv
// Shared sprite constants, scroll FSM encoding and the wrap-around adder.
// Combinational helpers only; no latency and no flow control.
package sprite_pkg;

  localparam int ADDR_W   = 18;
  localparam int SCROLL_W = 12;

  // ROM word address of each strip's first pixel
  localparam int GROUND_BASE = 85015;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } scroll_state_t;

  // Both operands are below the strip width, so one subtraction is enough to wrap.
  function automatic logic [SCROLL_W-1:0] wrap_add(
    input logic [SCROLL_W-1:0] a,
    input logic [SCROLL_W-1:0] b,
    input logic [SCROLL_W:0]   width
  );
    logic [SCROLL_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= width)
      sum = sum - width;
    return sum[SCROLL_W-1:0];
  endfunction

endpackage

// File: rtl/scroll_ctrl.sv
// Run/halt FSM with speed ramp and horizontal scroll offset; updates once per frame_tick.
// Registered outputs, one Clk50 of latency; no backpressure, ticks outside RUN are dropped.
module scroll_ctrl import sprite_pkg::*; #(
  parameter int STRIP_W      = 2400,
  parameter int SPEED_MAX    = 8,
  parameter int ACCEL_FRAMES = 300
) (
  input  logic                Clk50,
  input  logic                Reset,
  input  logic                frame_tick,
  input  logic                run,
  input  logic                halt,
  input  logic [3:0]          speed_init,
  output logic [SCROLL_W-1:0] scroll_pos,
  output scroll_state_t       state
);

  localparam int CNT_W = $clog2(ACCEL_FRAMES + 1);

  logic [3:0]       speed;
  logic [CNT_W-1:0] frame_cnt;
  logic [3:0]       speed_load;
  logic             start;

  assign speed_load = (speed_init > 4'(SPEED_MAX)) ? 4'(SPEED_MAX) : speed_init;
  // halt outranks run when both arrive together
  assign start      = run && !halt;

  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      scroll_pos <= '0;
      speed      <= '0;
      frame_cnt  <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state      <= ST_RUN;
            scroll_pos <= '0;
            speed      <= speed_load;
            frame_cnt  <= '0;
          end
        end
        ST_RUN: begin
          if (halt)
            state <= ST_HALT;
          if (frame_tick) begin
            scroll_pos <= wrap_add(scroll_pos, {8'd0, speed}, (SCROLL_W+1)'(STRIP_W));
            if (frame_cnt == CNT_W'(ACCEL_FRAMES - 1)) begin
              frame_cnt <= '0;
              if (speed < 4'(SPEED_MAX))
                speed <= speed + 4'd1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/scroll_layer.sv
// Scrolling ground strip: window tests and ROM address generation over a wrapping strip.
// address has one Clk50 of latency, window flags are combinational; no backpressure.
module scroll_layer #(
  parameter int BASE         = sprite_pkg::GROUND_BASE,
  parameter int STRIP_W      = 2400,
  parameter int STRIP_H      = 24,
  parameter int WIN_W        = 640,
  parameter int POS_Y        = 400,
  parameter int ADDR_W       = sprite_pkg::ADDR_W,
  parameter int SPEED_MAX    = 8,
  parameter int ACCEL_FRAMES = 300
) (
  input  logic              Clk50,
  input  logic              Reset,
  input  logic              frame_tick,
  input  logic              run,
  input  logic              halt,
  input  logic [3:0]        speed_init,
  input  logic [9:0]        WriteX,
  input  logic [9:0]        WriteY,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic              layer_on_wr,
  output logic              layer_on_dr,
  output logic [ADDR_W-1:0] address,
  output logic [11:0]       scroll_pos,
  output logic [1:0]        state
);
  import sprite_pkg::*;

  scroll_state_t     fsm_state;
  logic [11:0]       col;
  logic [9:0]        row;
  logic [31:0]       addr_calc;

  scroll_ctrl #(
    .STRIP_W      (STRIP_W),
    .SPEED_MAX    (SPEED_MAX),
    .ACCEL_FRAMES (ACCEL_FRAMES)
  ) u_ctrl (
    .Clk50      (Clk50),
    .Reset      (Reset),
    .frame_tick (frame_tick),
    .run        (run),
    .halt       (halt),
    .speed_init (speed_init),
    .scroll_pos (scroll_pos),
    .state      (fsm_state)
  );

  assign state = fsm_state;

  assign layer_on_wr = ({1'b0, WriteX} < 11'(WIN_W)) &&
                       ({1'b0, WriteY} >= 11'(POS_Y)) &&
                       ({1'b0, WriteY} < 11'(POS_Y + STRIP_H));
  assign layer_on_dr = ({1'b0, DrawX} < 11'(WIN_W)) &&
                       ({1'b0, DrawY} >= 11'(POS_Y)) &&
                       ({1'b0, DrawY} < 11'(POS_Y + STRIP_H));

  // Each row wraps on its own, so the column depends only on X and the scroll offset
  assign col       = wrap_add(scroll_pos, {2'b00, WriteX}, 13'(STRIP_W));
  assign row       = WriteY - 10'(POS_Y);
  assign addr_calc = 32'(BASE) + 32'(row) * 32'(STRIP_W) + 32'(col);

  always_ff @(posedge Clk50 or posedge Reset) begin
    if (Reset)
      address <= ADDR_W'(BASE);
    else if (layer_on_wr)
      address <= addr_calc[ADDR_W-1:0];
    else
      address <= ADDR_W'(BASE);
  end

endmodule
